pc_unit: RTL

Program-counter stage that sits directly downstream of the ALU's `True` condition flag and upstream of instruction memory. On each enabled step it selects the next instruction address: sequential, jump, conditional branch on `True`, call, or return. It keeps calls and returns on an internal return-address stack. It also implements processor halt/resume and a sticky fault state for stack misuse.

---
 rtl/pc_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program-counter stage: selects the next instruction address each enabled step
// (sequential, jump, conditional branch, call, return) with halt/resume and a sticky fault state.
module pc_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int STACK_DEPTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          Enable,
  input  logic                          True,
  input  logic [2:0]                    PC_Op,
  input  logic [ADDR_WIDTH-1:0]         Target,
  input  logic                          Resume,
  output logic [ADDR_WIDTH-1:0]         PC,
  output logic                          Halted,
  output logic                          Fault,
  output logic                          Stack_Overflow,
  output logic                          Stack_Underflow,
  output logic [$clog2(STACK_DEPTH):0]  Depth,
  output logic                          Branch_Taken
);

  localparam int PTR_W   = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = PTR_W + 1;

  localparam logic [2:0] OP_NEXT     = 3'd0;
  localparam logic [2:0] OP_JUMP     = 3'd1;
  localparam logic [2:0] OP_BR_TRUE  = 3'd2;
  localparam logic [2:0] OP_BR_FALSE = 3'd3;
  localparam logic [2:0] OP_CALL     = 3'd4;
  localparam logic [2:0] OP_RET      = 3'd5;
  localparam logic [2:0] OP_HALT     = 3'd6;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE    = ADDR_WIDTH'(1);
  localparam logic [DEPTH_W-1:0]    DEPTH_ONE = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0]    DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   stack [STACK_DEPTH];
  logic [ADDR_WIDTH-1:0]   pc_inc;
  logic [DEPTH_W-1:0]      depth_dec;
  logic [PTR_W-1:0]        push_idx;
  logic [PTR_W-1:0]        top_idx;
  logic                    full;
  logic                    empty;
  logic                    do_push;

  always_comb begin
    pc_inc    = PC + PC_ONE;
    depth_dec = Depth - DEPTH_ONE;
    push_idx  = Depth[PTR_W-1:0];
    top_idx   = depth_dec[PTR_W-1:0];
    full      = (Depth == DEPTH_MAX);
    empty     = (Depth == '0);
    do_push   = (state == RUN) && Enable && (PC_Op == OP_CALL) && !full;
  end

  // Entries are never cleared; a write landing on a reset edge is harmless
  // because Depth returns to 0 and no entry is considered valid.
  always_ff @(posedge Clock) begin
    if (do_push) stack[push_idx] <= pc_inc;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state           <= RUN;
      PC              <= RESET_PC;
      Depth           <= '0;
      Stack_Overflow  <= 1'b0;
      Stack_Underflow <= 1'b0;
      Branch_Taken    <= 1'b0;
    end else begin
      Branch_Taken <= 1'b0;
      case (state)
        RUN: begin
          if (Enable) begin
            case (PC_Op)
              OP_JUMP: begin
                PC           <= Target;
                Branch_Taken <= 1'b1;
              end
              OP_BR_TRUE: begin
                PC           <= True ? Target : pc_inc;
                Branch_Taken <= True;
              end
              OP_BR_FALSE: begin
                PC           <= True ? pc_inc : Target;
                Branch_Taken <= !True;
              end
              OP_CALL: begin
                if (!full) begin
                  PC           <= Target;
                  Depth        <= Depth + DEPTH_ONE;
                  Branch_Taken <= 1'b1;
                end else begin
                  Stack_Overflow <= 1'b1;
                  state          <= FAULT;
                end
              end
              OP_RET: begin
                if (!empty) begin
                  PC           <= stack[top_idx];
                  Depth        <= depth_dec;
                  Branch_Taken <= 1'b1;
                end else begin
                  Stack_Underflow <= 1'b1;
                  state           <= FAULT;
                end
              end
              OP_HALT: state <= HALT;
              default: PC <= pc_inc;
            endcase
          end
        end
        HALT: begin
          if (Resume) begin
            PC    <= pc_inc;
            state <= RUN;
          end
        end
        default: ; // FAULT: frozen until reset
      endcase
    end
  end

  assign Halted = (state == HALT);
  assign Fault  = (state == FAULT);

endmodule
